// File: rtl/axi_line_write_responder_if.sv
// Write-channel bundle between the dcache writeback master and the line responder:
// AW/W/B AXI channels plus the assembled-line valid/ready port toward the next level.
interface axi_line_write_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int ID_W   = 4
);
  logic                      aw_valid;
  logic                      aw_ready;
  logic [ID_W-1:0]           aw_id;
  logic [ADDR_W-1:0]         aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic [2:0]                aw_snoop;
  logic                      w_valid;
  logic                      w_ready;
  logic [DATA_W-1:0]         w_data;
  logic [DATA_W/8-1:0]       w_strb;
  logic                      w_last;
  logic                      b_valid;
  logic                      b_ready;
  logic [ID_W-1:0]           b_id;
  logic [1:0]                b_resp;
  logic                      line_valid;
  logic                      line_ready;
  logic [ADDR_W-1:0]         line_addr;
  logic [BEATS*DATA_W-1:0]   line_data;
  logic [BEATS*DATA_W/8-1:0] line_mask;
  logic                      line_dirty;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_snoop,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    output line_valid, line_addr, line_data, line_mask, line_dirty,
    input  line_ready
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_snoop,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    input  line_valid, line_addr, line_data, line_mask, line_dirty,
    output line_ready
  );
endinterface

// File: rtl/axi_line_write_responder.sv
// Slave end of the dcache writeback bus: collects one full-line burst, forwards
// dirty lines downstream and returns a single B response. One burst in flight.
module axi_line_write_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int ID_W   = 4
) (
  input logic                       clk,
  input logic                       rst,
  axi_line_write_responder_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LINE_W = BEATS * DATA_W;
  localparam int MASK_W = BEATS * STRB_W;
  localparam int OFF_W  = $clog2(MASK_W);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [7:0]       LEN_OK      = 8'(BEATS - 1);
  localparam logic [2:0]       SIZE_OK     = 3'($clog2(STRB_W));
  localparam logic [1:0]       BURST_INCR  = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(BEATS - 1);
  localparam logic [2:0]       SNOOP_CLEAN = 3'b010;
  localparam logic [2:0]       SNOOP_EVICT = 3'b101;
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_OUT, S_RESP} state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_snoop;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [LINE_W-1:0]   r_data;
  logic [MASK_W-1:0]   r_mask;
  logic                r_dirty;
  logic                r_aw_ready;
  logic                r_w_ready;
  logic                r_b_valid;
  logic [1:0]          r_b_resp;
  logic [ID_W-1:0]     r_b_id;
  logic                r_line_valid;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_err;
  logic                w_beat_end;
  logic                w_beat_err;
  logic                w_burst_err;
  logic [MASK_W-1:0]   w_sel;
  logic [LINE_W-1:0]   w_data_merged;
  logic [MASK_W-1:0]   w_mask_merged;

  assign w_aw_hs = bus.aw_valid & r_aw_ready;
  assign w_w_hs  = bus.w_valid & r_w_ready;

  assign w_aw_err = (bus.aw_len != LEN_OK) | (bus.aw_size != SIZE_OK) |
                    (bus.aw_burst != BURST_INCR) | (bus.aw_addr[OFF_W-1:0] != '0);

  // A burst ends on w_last or on the final beat slot, whichever comes first;
  // any disagreement between the two marks the burst as malformed.
  assign w_beat_end  = bus.w_last | (r_cnt == CNT_MAX);
  assign w_beat_err  = bus.w_last ? (r_cnt != CNT_MAX) : (r_cnt == CNT_MAX);
  assign w_burst_err = r_err | w_beat_err;

  for (genvar gi = 0; gi < MASK_W; gi++) begin : g_byte
    localparam int BEAT = gi / STRB_W;
    localparam int LANE = gi % STRB_W;
    assign w_sel[gi] = (r_cnt == CNT_W'(BEAT)) & bus.w_strb[LANE];
    assign w_data_merged[gi*8 +: 8] = w_sel[gi] ? bus.w_data[LANE*8 +: 8] : r_data[gi*8 +: 8];
    assign w_mask_merged[gi] = r_mask[gi] | w_sel[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_id         <= '0;
      r_addr       <= '0;
      r_snoop      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_mask       <= '0;
      r_dirty      <= 1'b0;
      r_aw_ready   <= 1'b0;
      r_w_ready    <= 1'b0;
      r_b_valid    <= 1'b0;
      r_b_resp     <= '0;
      r_b_id       <= '0;
      r_line_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_aw_ready <= 1'b1;
          if (w_aw_hs) begin
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b1;
            r_id       <= bus.aw_id;
            r_addr     <= {bus.aw_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_snoop    <= bus.aw_snoop;
            r_err      <= w_aw_err;
            r_cnt      <= '0;
            r_data     <= '0;
            r_mask     <= '0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_w_hs) begin
            r_data <= w_data_merged;
            r_mask <= w_mask_merged;
            r_cnt  <= r_cnt + 1'b1;
            if (w_beat_end) begin
              r_w_ready <= 1'b0;
              if (w_burst_err || r_snoop == SNOOP_EVICT) begin
                // Evicted clean lines are dropped: only the response goes back.
                r_b_valid <= 1'b1;
                r_b_resp  <= w_burst_err ? RESP_SLVERR : RESP_OKAY;
                r_b_id    <= r_id;
                r_state   <= S_RESP;
              end else begin
                r_line_valid <= 1'b1;
                r_dirty      <= (r_snoop == SNOOP_CLEAN);
                r_state      <= S_OUT;
              end
            end
          end
        end
        S_OUT: begin
          if (bus.line_ready) begin
            r_line_valid <= 1'b0;
            r_b_valid    <= 1'b1;
            r_b_resp     <= RESP_OKAY;
            r_b_id       <= r_id;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.b_ready) begin
            r_b_valid  <= 1'b0;
            r_aw_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.aw_ready   = r_aw_ready;
  assign bus.w_ready    = r_w_ready;
  assign bus.b_valid    = r_b_valid;
  assign bus.b_id       = r_b_id;
  assign bus.b_resp     = r_b_resp;
  assign bus.line_valid = r_line_valid;
  assign bus.line_addr  = r_addr;
  assign bus.line_data  = r_data;
  assign bus.line_mask  = r_mask;
  assign bus.line_dirty = r_dirty;
endmodule

// File: doc/axi_line_write_responder.md
Name: axi_line_write_responder

Overview:
- AXI/ACE write-channel responder (slave end) for full-cacheline writeback bursts issued by the dcache writeback path.
- Accepts one AW, collects the W beats into a line buffer, and forwards dirty lines to the next level over a valid/ready line port.
- Returns one B response per burst. Sits at the L2/memory side of the dcache write bus.
- Single outstanding transaction, no reordering.

Parameters:
ADDR_W, 32, physical address width (PADDR_SIZE)
DATA_W, 64, AXI data beat width (XLEN)
BEATS, 8, beats per cacheline; line = BEATS*DATA_W/8 bytes
ID_W, 4, AXI id width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
aw_valid  in  1  write address valid
aw_ready  out  1  write address ready
aw_id  in  ID_W  transaction id
aw_addr  in  ADDR_W  line address
aw_len  in  8  burst length-1
aw_size  in  3  log2 bytes per beat
aw_burst  in  2  burst type
aw_snoop  in  3  ACE write op: 3'b010 WriteClean, 3'b101 WriteEvict
w_valid  in  1  write data valid
w_ready  out  1  write data ready
w_data  in  DATA_W  beat data
w_strb  in  DATA_W/8  byte strobes
w_last  in  1  last beat
b_valid  out  1  response valid
b_ready  in  1  response ready
b_id  out  ID_W  echoed aw_id
b_resp  out  2  2'b00 OKAY, 2'b10 SLVERR
line_valid  out  1  assembled line valid
line_ready  in  1  downstream accepts line
line_addr  out  ADDR_W  line-aligned address (offset bits zero)
line_data  out  BEATS*DATA_W  line, beat 0 in LSBs
line_mask  out  BEATS*DATA_W/8  accumulated byte strobes
line_dirty  out  1  1 for WriteClean

Behaviour:
- Reset: rst==0 sampled at posedge clk forces state IDLE.
  - aw_ready, w_ready, b_valid and line_valid go to 0; b_resp and b_id go to 0; beat counter goes to 0.
  - line_data/line_mask cleared. Any partial burst is discarded with no B response.
  - Reset is synchronous only; there is no asynchronous path.
- States: IDLE -> DATA -> (OUT) -> RESP -> IDLE. All outputs are registered or decoded from state only.
- IDLE:
  - aw_ready=1, all others 0.
  - On aw_valid&aw_ready, latch id, addr with low log2(BEATS*DATA_W/8) bits zeroed, and snoop. Clear the line buffer and mask, cnt=0.
  - err=1 if any of: aw_len!=BEATS-1, aw_size!=log2(DATA_W/8), aw_burst!=2'b01, or aw_addr offset bits nonzero.
  - Next state DATA.
- DATA:
  - w_ready=1, aw_ready=0.
  - Each w_valid&w_ready writes beat cnt: only bytes with w_strb=1 are updated, and line_mask bits are ORed with w_strb. cnt increments, width log2(BEATS).
  - The burst ends on the first beat where w_last=1 or cnt==BEATS-1.
  - err additionally set if w_last=1 with cnt<BEATS-1, or w_last=0 with cnt==BEATS-1.
  - Trailing beats after the end beat are a protocol violation and are not supported.
  - At burst end:
    - err=1 -> RESP with b_resp=SLVERR, no line forwarded.
    - WriteEvict (3'b101) -> RESP with OKAY, no line forwarded; the clean copy is dropped.
    - Otherwise -> OUT.
- OUT:
  - line_valid=1; line_addr, line_data, line_mask and line_dirty are held stable until line_ready.
  - On line_valid&line_ready -> RESP next cycle, b_resp=OKAY.
  - line_ready asserted with line_valid low is ignored.
- RESP:
  - b_valid=1 with b_id=latched id, held stable until b_ready.
  - On the handshake -> IDLE; aw_ready rises the next cycle.
- Latency: minimum AW-to-B for a clean forward with ready tied high is 1 (AW) + BEATS (W) + 1 (OUT) + 1 (RESP) = BEATS+3 cycles; B handshakes on cycle BEATS+3 after AW.
- Back-to-back bursts: a new AW is accepted no earlier than the cycle after the B handshake. Never more than one burst in flight.
- w_valid during IDLE/OUT/RESP is not accepted (w_ready=0). aw_valid during non-IDLE states is held off (aw_ready=0).

Test Plan:
- WriteClean, addr 0x8000_1040, BEATS=8, data beat i=0x1111_1111_0000_0000+i, strb all 1s, line_ready/b_ready=1 -> line_valid 1 cycle with line_addr 0x8000_1040, mask all 1s, line_dirty=1; b_resp=00, b_id=aw_id; B at cycle 11 after AW.
- WriteEvict same line -> no line_valid pulse; b_valid with OKAY after 8 beats.
- aw_len=3 (error) with 4 beats, w_last on beat 3 -> no line output, b_resp=2'b10; next AW accepted after B.
- line_ready held low 5 cycles, b_ready low 3 cycles -> line_valid/line_data and b_valid/b_id stable throughout; no AW or W accepted meanwhile.
- Partial strobes: beat 2 strb=0x0F, others 0x00 -> line_mask=0x0000_0000_000F_0000, only bytes 16-19 updated, rest zero.
- Reset asserted after beat 4 of a burst -> next cycle aw_ready=1, w_ready=0, b_valid=0, line_valid=0; fresh burst completes normally.
